// File: rtl/alu_pkg.sv
// Shared opcodes and FSM state encodings for pipelined_alu_seq and alu_comb_core.
// The legacy 3-bit ALU command codes are reused unchanged as op[2:0] with op[3]=0.
package alu_pkg;

    localparam logic [2:0] CMD_ADD  = 3'd0;
    localparam logic [2:0] CMD_SUB  = 3'd1;
    localparam logic [2:0] CMD_XOR  = 3'd2;
    localparam logic [2:0] CMD_SLT  = 3'd3;
    localparam logic [2:0] CMD_AND  = 3'd4;
    localparam logic [2:0] CMD_NAND = 3'd5;
    localparam logic [2:0] CMD_NOR  = 3'd6;
    localparam logic [2:0] CMD_OR   = 3'd7;

    localparam logic [3:0] OP_ADD  = {1'b0, CMD_ADD};
    localparam logic [3:0] OP_SUB  = {1'b0, CMD_SUB};
    localparam logic [3:0] OP_XOR  = {1'b0, CMD_XOR};
    localparam logic [3:0] OP_SLT  = {1'b0, CMD_SLT};
    localparam logic [3:0] OP_AND  = {1'b0, CMD_AND};
    localparam logic [3:0] OP_NAND = {1'b0, CMD_NAND};
    localparam logic [3:0] OP_NOR  = {1'b0, CMD_NOR};
    localparam logic [3:0] OP_OR   = {1'b0, CMD_OR};
    localparam logic [3:0] OP_MUL  = 4'h8;
    localparam logic [3:0] OP_SLL  = 4'h9;
    localparam logic [3:0] OP_SRL  = 4'hA;
    localparam logic [3:0] OP_SRA  = 4'hB;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/alu_comb_core.sv
// Single-cycle ALU datapath: add/sub/logic/signed SLT/barrel shifts with carry and overflow.
// MUL and opcodes C-F are reported as illegal here; the top level decides what MUL means.
module alu_comb_core
    import alu_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic [3:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] result_o,
    output logic             carry_o,
    output logic             overflow_o,
    output logic             illegal_o
);

    logic [WIDTH:0]     add_w;
    logic [WIDTH:0]     sub_w;
    logic               add_ovf;
    logic               sub_ovf;
    logic [SHAMT_W-1:0] shamt;

    assign shamt = b_i[SHAMT_W-1:0];
    assign add_w = {1'b0, a_i} + {1'b0, b_i};
    assign sub_w = {1'b0, a_i} + {1'b0, ~b_i} + {{WIDTH{1'b0}}, 1'b1};

    // Same-sign operands producing a different-sign result (carry into MSB ^ carry out).
    assign add_ovf = (a_i[WIDTH-1] == b_i[WIDTH-1]) && (add_w[WIDTH-1] != a_i[WIDTH-1]);
    assign sub_ovf = (a_i[WIDTH-1] != b_i[WIDTH-1]) && (sub_w[WIDTH-1] != a_i[WIDTH-1]);

    always_comb begin
        result_o   = '0;
        carry_o    = 1'b0;
        overflow_o = 1'b0;
        illegal_o  = 1'b0;
        case (op_i)
            OP_ADD: begin
                result_o   = add_w[WIDTH-1:0];
                carry_o    = add_w[WIDTH];
                overflow_o = add_ovf;
            end
            OP_SUB: begin
                result_o   = sub_w[WIDTH-1:0];
                carry_o    = sub_w[WIDTH];
                overflow_o = sub_ovf;
            end
            OP_XOR:  result_o = a_i ^ b_i;
            OP_SLT: begin
                result_o   = {{(WIDTH-1){1'b0}}, sub_w[WIDTH-1] ^ sub_ovf};
                overflow_o = sub_ovf;
            end
            OP_AND:  result_o = a_i & b_i;
            OP_NAND: result_o = ~(a_i & b_i);
            OP_NOR:  result_o = ~(a_i | b_i);
            OP_OR:   result_o = a_i | b_i;
            OP_SLL:  result_o = a_i << shamt;
            OP_SRL:  result_o = a_i >> shamt;
            OP_SRA:  result_o = $signed(a_i) >>> shamt;
            default: illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/pipelined_alu_seq.sv
// Handshaked ALU: valid/ready in, result+flags held until consumed. Define
// PIPELINED_ALU_MUL_EN to build the iterative shift-add multiplier (op 8); otherwise op 8 is illegal.
//   state   | meaning
//   IDLE    | ready for a new op (in_ready=1)
//   BUSY    | multiplier iterating, one partial-product bit per cycle
//   DONE    | result/flags valid, waiting for consumer
module pipelined_alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             overflow,
    output logic             zero,
    output logic             illegal
);

    state_t           state_q, state_d;
    logic             accept;
    logic             consume;
    logic [WIDTH-1:0] core_res;
    logic             core_carry, core_ovf, core_ill;
    logic [WIDTH-1:0] result_q, result_d;
    logic             carry_q, carry_d;
    logic             overflow_q, overflow_d;
    logic             illegal_q, illegal_d;

    assign accept  = in_valid & in_ready;
    assign consume = out_valid & out_ready;

    alu_comb_core #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W)) u_core (
        .op_i       (op),
        .a_i        (a),
        .b_i        (b),
        .result_o   (core_res),
        .carry_o    (core_carry),
        .overflow_o (core_ovf),
        .illegal_o  (core_ill)
    );

`ifdef PIPELINED_ALU_MUL_EN
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [WIDTH-1:0]   acc_q, acc_d, acc_step;
    logic [SHAMT_W-1:0] cnt_q, cnt_d;
    logic               mul_last;

    assign acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);
    assign mul_last = (state_q == ST_BUSY) && (cnt_q == SHAMT_W'(WIDTH-1));

    always_comb begin
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        if (accept && op == OP_MUL) begin
            mcand_d  = a;
            mplier_d = b;
            acc_d    = '0;
            cnt_d    = '0;
        end else if (state_q == ST_BUSY) begin
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            acc_d    = acc_step;
            cnt_d    = cnt_q + SHAMT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else begin
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) state_d = ST_DONE;
`ifdef PIPELINED_ALU_MUL_EN
                if (accept && op == OP_MUL) state_d = ST_BUSY;
`endif
            end
`ifdef PIPELINED_ALU_MUL_EN
            ST_BUSY: if (mul_last) state_d = ST_DONE;
`endif
            ST_DONE: if (consume) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == ST_IDLE);
        out_valid = (state_q == ST_DONE);
        // Gated so all flags read 0 out of reset even though result_q is 0.
        zero      = out_valid && (result_q == '0);
    end

    always_comb begin
        result_d   = result_q;
        carry_d    = carry_q;
        overflow_d = overflow_q;
        illegal_d  = illegal_q;
        if (accept) begin
            result_d   = core_res;
            carry_d    = core_carry;
            overflow_d = core_ovf;
            illegal_d  = core_ill;
`ifdef PIPELINED_ALU_MUL_EN
            if (op == OP_MUL) begin
                result_d   = '0;
                carry_d    = 1'b0;
                overflow_d = 1'b0;
                illegal_d  = 1'b0;
            end
`endif
        end
`ifdef PIPELINED_ALU_MUL_EN
        if (mul_last) result_d = acc_step;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_q   <= '0;
            carry_q    <= 1'b0;
            overflow_q <= 1'b0;
            illegal_q  <= 1'b0;
        end else begin
            result_q   <= result_d;
            carry_q    <= carry_d;
            overflow_q <= overflow_d;
            illegal_q  <= illegal_d;
        end
    end

    assign result   = result_q;
    assign carry    = carry_q;
    assign overflow = overflow_q;
    assign illegal  = illegal_q;

endmodule

// File: tb/tb_pipelined_alu_seq.sv
// Randomised self-checking bench for pipelined_alu_seq (WIDTH=32) against an arithmetic model.
// Honours PIPELINED_ALU_MUL_EN the same way as the design.
module tb_pipelined_alu_seq;
    import alu_pkg::*;

    typedef struct packed {
        logic [31:0] r;
        logic        c;
        logic        v;
        logic        ill;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  op;
    logic [31:0] a, b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        carry, overflow, zero, illegal;

    int   n_checks = 0;
    int   n_fail   = 0;
    bit   chk_en   = 0;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    pipelined_alu_seq #(.WIDTH(32), .SHAMT_W(5)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .carry     (carry),
        .overflow  (overflow),
        .zero      (zero),
        .illegal   (illegal)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    function automatic bit out_of_range(input longint s);
        return (s > 64'sd2147483647) || (s < -64'sd2147483648);
    endfunction

    // Expected result from plain integer arithmetic on the opcode's meaning.
    function automatic exp_t model(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
        exp_t        e;
        longint      sx, sy;
        logic [32:0] u;
        e  = '0;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        case (o)
            4'd0: begin
                u = {1'b0, x} + {1'b0, y};
                e.r = u[31:0]; e.c = u[32]; e.v = out_of_range(sx + sy);
            end
            4'd1: begin
                e.r = x - y; e.c = (x >= y); e.v = out_of_range(sx - sy);
            end
            4'd2:  e.r = x ^ y;
            4'd3: begin
                e.r = (sx < sy) ? 32'd1 : 32'd0; e.v = out_of_range(sx - sy);
            end
            4'd4:  e.r = x & y;
            4'd5:  e.r = ~(x & y);
            4'd6:  e.r = ~(x | y);
            4'd7:  e.r = x | y;
`ifdef PIPELINED_ALU_MUL_EN
            4'd8:  e.r = x * y;
`else
            4'd8:  e.ill = 1'b1;
`endif
            4'd9:  e.r = x << y[4:0];
            4'd10: e.r = x >> y[4:0];
            4'd11: e.r = $signed(x) >>> y[4:0];
            default: e.ill = 1'b1;
        endcase
        return e;
    endfunction

    // Every cycle: held result must match the oldest accepted op; in_ready must follow state.
    always @(negedge clk) begin
        if (rst_n && chk_en) begin
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_out_valid", 64'(out_valid), 64'd0);
                end else begin
                    check("outputs", {result, carry, overflow, zero, illegal},
                          {exp_q[0].r, exp_q[0].c, exp_q[0].v, (exp_q[0].r == 32'd0), exp_q[0].ill});
                    check("in_ready_while_done", 64'(in_ready), 64'd0);
                    if (out_ready) void'(exp_q.pop_front());
                end
            end else begin
                check("in_ready_state", 64'(in_ready), (exp_q.size() == 0) ? 64'd1 : 64'd0);
            end
        end
    end

    task automatic do_op(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                         input int hold, input bit rdy_high);
        int waitc;
        int lat;
        int exp_lat;
        op = o; a = x; b = y; in_valid = 1'b1; out_ready = rdy_high;
        waitc = 0;
        @(negedge clk);
        while (!in_ready && waitc < 50) begin
            waitc++;
            @(negedge clk);
        end
        check("accept_wait", 64'(waitc), 64'd0);
        if (!in_ready) return;
        @(posedge clk); #1;
        exp_q.push_back(model(o, x, y));
        in_valid = 1'($urandom_range(0, 1)); op = 4'($urandom); a = $urandom; b = $urandom;
        lat = 0;
        @(negedge clk);
        while (!out_valid && lat < 100) begin
            lat++;
            @(negedge clk);
        end
`ifdef PIPELINED_ALU_MUL_EN
        exp_lat = (o == OP_MUL) ? 32 : 0;
`else
        exp_lat = 0;
`endif
        check("latency", 64'(lat), 64'(exp_lat));
        repeat (hold) begin
            @(posedge clk); #1;
            in_valid = 1'b1; op = 4'($urandom); a = $urandom; b = $urandom;
            @(negedge clk);
        end
        @(posedge clk); #1;
        out_ready = 1'b1; in_valid = 1'b0;
        if (!rdy_high) begin
            @(posedge clk); #1;
            out_ready = 1'b0;
        end
    endtask

    task automatic check_reset_state(input string name);
        check(name, {out_valid, in_ready, result, carry, overflow, zero, illegal},
              {1'b0, 1'b1, 32'd0, 4'd0});
    endtask

    function automatic logic [31:0] pick_operand();
        logic [31:0] specials [5];
        specials[0] = 32'h0; specials[1] = 32'h1; specials[2] = 32'h7FFF_FFFF;
        specials[3] = 32'h8000_0000; specials[4] = 32'hFFFF_FFFF;
        if ($urandom_range(0, 3) == 0) return specials[$urandom_range(0, 4)];
        return $urandom;
    endfunction

    initial begin
        exp_t e;
        rst_n = 1'b0; in_valid = 1'b0; op = '0; a = '0; b = '0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 check_reset_state("reset_in_reset");
        @(negedge clk) rst_n = 1'b1;
        #1 check_reset_state("reset_released");

        e = model(OP_ADD, 32'h7FFF_FFFF, 32'h1);
        check("model_add_ovf", 64'(e), 64'({32'h8000_0000, 1'b0, 1'b1, 1'b0}));
        e = model(OP_SUB, 32'd5, 32'd5);
        check("model_sub_zero", 64'(e), 64'({32'h0, 1'b1, 1'b0, 1'b0}));
        e = model(OP_SLT, 32'h8000_0000, 32'h1);
        check("model_slt_neg", 64'(e), 64'({32'h1, 1'b0, 1'b1, 1'b0}));
        e = model(OP_SLT, 32'd3, 32'd2);
        check("model_slt_pos", 64'(e), 64'({32'h0, 1'b0, 1'b0, 1'b0}));
        e = model(OP_SRA, 32'hF000_0000, 32'd4);
        check("model_sra", 64'(e.r), 64'h FF00_0000);
        e = model(OP_SRL, 32'hF000_0000, 32'd4);
        check("model_srl", 64'(e.r), 64'h 0F00_0000);
        e = model(OP_SLL, 32'h1234_5678, 32'd0);
        check("model_sll0", 64'(e.r), 64'h 1234_5678);
        e = model(OP_MUL, 32'h0001_0000, 32'h0001_0001);
`ifdef PIPELINED_ALU_MUL_EN
        check("model_mul", 64'(e), 64'({32'h0001_0000, 1'b0, 1'b0, 1'b0}));
`else
        check("model_mul_illegal", 64'(e), 64'({32'h0, 1'b0, 1'b0, 1'b1}));
`endif

        chk_en = 1'b1;
        @(posedge clk); #1;
        do_op(OP_ADD, 32'h7FFF_FFFF, 32'h1, 0, 1'b1);
        do_op(OP_SUB, 32'd5, 32'd5, 0, 1'b1);
        do_op(OP_SLT, 32'h8000_0000, 32'h1, 0, 1'b1);
        do_op(OP_SLT, 32'd3, 32'd2, 1, 1'b0);
        do_op(OP_SRA, 32'hF000_0000, 32'd4, 0, 1'b1);
        do_op(OP_SRL, 32'hF000_0000, 32'd4, 0, 1'b1);
        do_op(OP_SLL, 32'h1234_5678, 32'd0, 0, 1'b1);
        do_op(OP_MUL, 32'h0001_0000, 32'h0001_0001, 2, 1'b0);
        do_op(4'hD, 32'hDEAD_BEEF, 32'h1, 0, 1'b1);
        do_op(OP_ADD, 32'd1, 32'd2, 5, 1'b0);

        for (int i = 0; i < 60; i++) begin
            bit rh;
            rh = 1'($urandom_range(0, 1));
            do_op(4'($urandom_range(0, 15)), pick_operand(), pick_operand(),
                  rh ? 0 : int'($urandom_range(0, 3)), rh);
        end

        // Abort a multiply mid-flight with asynchronous reset.
        chk_en = 1'b0;
        op = OP_MUL; a = 32'h1234; b = 32'h5678; in_valid = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1 check_reset_state("reset_mid_op_async");
        @(posedge clk); #1;
        check_reset_state("reset_mid_op_edge");
        rst_n = 1'b1;
        exp_q.delete();
        @(posedge clk); #1;
        chk_en = 1'b1;
        do_op(OP_ADD, 32'd2, 32'd3, 0, 1'b1);
        do_op(OP_XOR, 32'hFFFF_0000, 32'h0F0F_0F0F, 0, 1'b1);

        repeat (3) @(negedge clk);
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
